snake_random_box: RTL and testbench



---
 rtl/snake_pkg.sv | 18 +
 rtl/lfsr16.sv | 46 ++++
 rtl/snake_random_box.sv | 109 ++++++++++
 tb/tb_snake_random_box.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// snake_pkg
// Shared constants and types for the Snake game blocks: screen size,
// grid geometry (cell size as a shift, column and row counts), the LFSR
// feedback mask, and the pixel coordinate type used on the VGA side.
package snake_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int CELL_SHIFT = 4;
  localparam int COLS       = 40;
  localparam int ROWS       = 30;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 in right-shifting Galois form
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef logic [9:0] coord_t;

endpackage

// File: rtl/lfsr16.sv
// lfsr16
// 16-bit right-shifting Galois LFSR that steps every clock. A synchronous
// reset returns it to SEED. A load overrides the step for that cycle.
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst        - synchronous active-high reset to SEED
//   load_en    - when high, the next state is load_value instead of the step
//   load_value - replacement state; the caller keeps it nonzero
//   state      - current LFSR contents
module lfsr16
  import snake_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_en,
  input  logic [15:0] load_value,
  output logic [15:0] state
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // The bit falling off the right end decides whether the taps are applied
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LFSR_MASK;
    end
    if (load_en) begin
      lfsr_d = load_value;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state = lfsr_q;

endmodule

// File: rtl/snake_random_box.sv
// snake_random_box
// Places the Snake food box at a pseudo-random grid-aligned pixel position.
// A free-running LFSR is sampled on each rising edge of I_drive and folded
// into the column/row range; the result is scaled up to pixels.
// Ports:
//   I_clk   - system clock
//   I_rst   - synchronous active-high reset; outputs return to screen centre
//   I_load  - while high, reseeds the LFSR from the free-running cycle counter
//   I_drive - request strobe; its rising edge produces a new position
//   O_box_x - box top-left x in pixels, multiple of the cell size
//   O_box_y - box top-left y in pixels, multiple of the cell size
// Optional feature macro: RANDOM_BOX_BORDER_EN keeps the box off the outer
// ring of wall cells.
module snake_random_box #(
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int          CELL_SHIFT = snake_pkg::CELL_SHIFT,
  parameter int          COLS       = snake_pkg::COLS,
  parameter int          ROWS       = snake_pkg::ROWS
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_load,
  input  logic       I_drive,
  output logic [9:0] O_box_x,
  output logic [9:0] O_box_y
);

  import snake_pkg::*;

`ifdef RANDOM_BOX_BORDER_EN
  localparam int NX     = COLS - 2;
  localparam int NY     = ROWS - 2;
  localparam int OFFSET = 1;
`else
  localparam int NX     = COLS;
  localparam int NY     = ROWS;
  localparam int OFFSET = 0;
`endif

  localparam int XW = $clog2(NX);
  localparam int YW = $clog2(NY);

  logic [15:0]   lfsr;
  logic [15:0]   cnt_q;
  logic [15:0]   cnt_d;
  logic          drive_prev_q;
  logic          drive_prev_d;
  coord_t        box_x_q;
  coord_t        box_x_d;
  coord_t        box_y_q;
  coord_t        box_y_d;
  logic          gen;
  logic [XW-1:0] vx;
  logic [XW-1:0] cx;
  logic [YW-1:0] vy;
  logic [YW-1:0] cy;
  logic          unused_bits;

  // Reseed value forces bit 0 high so the LFSR can never be loaded with zero
  lfsr16 #(
    .SEED(SEED)
  ) u_lfsr (
    .clk       (I_clk),
    .rst       (I_rst),
    .load_en   (I_load),
    .load_value({cnt_q[15:1], 1'b1}),
    .state     (lfsr)
  );

  // The field is less than twice the range, so one conditional subtract folds
  // it into range without a divider
  always_comb begin
    vx = lfsr[XW-1:0];
    vy = lfsr[8 +: YW];
    cx = (vx >= XW'(NX)) ? vx - XW'(NX) : vx;
    cy = (vy >= YW'(NY)) ? vy - YW'(NY) : vy;

    gen          = I_drive & ~drive_prev_q;
    cnt_d        = cnt_q + 16'd1;
    drive_prev_d = I_drive;
    box_x_d      = box_x_q;
    box_y_d      = box_y_q;
    if (gen) begin
      box_x_d = (coord_t'(cx) + coord_t'(OFFSET)) << CELL_SHIFT;
      box_y_d = (coord_t'(cy) + coord_t'(OFFSET)) << CELL_SHIFT;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      cnt_q        <= 16'd0;
      drive_prev_q <= 1'b0;
      box_x_q      <= coord_t'(SCREEN_W / 2);
      box_y_q      <= coord_t'(SCREEN_H / 2);
    end else begin
      cnt_q        <= cnt_d;
      drive_prev_q <= drive_prev_d;
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
    end
  end

  // Only some LFSR bits feed the mapping and the reseed ignores cnt bit 0
  assign unused_bits = ^{lfsr, cnt_q[0]};

  assign O_box_x = box_x_q;
  assign O_box_y = box_y_q;

endmodule

// File: tb/tb_snake_random_box.sv
// tb_snake_random_box
// Self-checking bench for snake_random_box: a constant-valued vector table
// for reset, first generations and edge cases, hand sequences for held
// drive, reseeding and reset collisions, and a long randomized run checked
// against a behavioural model of the box placement rules.
module tb_snake_random_box;

`ifdef RANDOM_BOX_BORDER_EN
  localparam int NX = 38;
  localparam int NY = 28;
  localparam int OFF = 1;
  localparam int X_ACE1 = 544;
  localparam int Y_ACE1 = 208;
  localparam int X_E270 = 176;
  localparam int Y_E270 = 48;
`else
  localparam int NX = 40;
  localparam int NY = 30;
  localparam int OFF = 0;
  localparam int X_ACE1 = 528;
  localparam int Y_ACE1 = 192;
  localparam int X_E270 = 128;
  localparam int Y_E270 = 32;
`endif
  localparam int XMIN = OFF * 16;
  localparam int XMAX = (NX - 1 + OFF) * 16;
  localparam int YMIN = OFF * 16;
  localparam int YMAX = (NY - 1 + OFF) * 16;

  logic       I_clk;
  logic       I_rst;
  logic       I_load;
  logic       I_drive;
  logic [9:0] O_box_x;
  logic [9:0] O_box_y;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int m_lfsr;
  int m_cnt;
  int m_x;
  int m_y;
  bit m_prev;

  typedef struct {
    bit rst;
    bit load;
    bit drive;
    int exp_x;
    int exp_y;
  } vec_t;

  vec_t tbl[12];

  bit colSeen[40];
  bit rowSeen[30];

  snake_random_box dut (
    .I_clk  (I_clk),
    .I_rst  (I_rst),
    .I_load (I_load),
    .I_drive(I_drive),
    .O_box_x(O_box_x),
    .O_box_y(O_box_y)
  );

  initial begin
    I_clk = 1'b0;
    forever #5 I_clk = ~I_clk;
  end

  function automatic int lfsrNext(input int l);
    if ((l % 2) == 1) return (l / 2) ^ 'hB400;
    return l / 2;
  endfunction

  // Food position rule: low six bits pick the column, bits 12..8 pick the
  // row, each reduced modulo the usable count, then scaled to 16 px cells
  task automatic modelStep(input bit rst, input bit load, input bit drive);
    if (rst) begin
      m_lfsr = 'hACE1;
      m_cnt  = 0;
      m_prev = 1'b0;
      m_x    = 320;
      m_y    = 240;
    end else begin
      if (drive && !m_prev) begin
        m_x = (((m_lfsr % 64) % NX) + OFF) * 16;
        m_y = ((((m_lfsr / 256) % 32) % NY) + OFF) * 16;
      end
      if (load) m_lfsr = (m_cnt / 2) * 2 + 1;
      else      m_lfsr = lfsrNext(m_lfsr);
      m_cnt  = (m_cnt + 1) % 65536;
      m_prev = drive;
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit load, input bit drive);
    @(negedge I_clk);
    I_rst   = rst;
    I_load  = load;
    I_drive = drive;
    @(posedge I_clk);
    modelStep(rst, load, drive);
    #1;
  endtask

  task automatic checkOutput(input string name, input int ex, input int ey);
    vectors++;
    if (O_box_x !== 10'(ex) || O_box_y !== 10'(ey)) begin
      miscompares++;
      $display("[TB] FAIL %s: got (%0d,%0d) expected (%0d,%0d)",
               name, O_box_x, O_box_y, ex, ey);
    end
  endtask

  task automatic checkRange(input string name);
    bit ok;
    vectors++;
    ok = (O_box_x[3:0] === 4'd0) && (O_box_y[3:0] === 4'd0) &&
         (int'(O_box_x) >= XMIN) && (int'(O_box_x) <= XMAX) &&
         (int'(O_box_y) >= YMIN) && (int'(O_box_y) <= YMAX);
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL %s: got (%0d,%0d) required grid-aligned in x %0d..%0d y %0d..%0d",
               name, O_box_x, O_box_y, XMIN, XMAX, YMIN, YMAX);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    vectors++;
    if (actual != expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic idleUntilCnt(input int target);
    for (int i = 0; i < 200 && m_cnt != target; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkValue("reachLoadCycle", m_cnt, target);
  endtask

  // Reseeds at cycles target and target+1, then records four generations
  task automatic loadAndSample(input int target, input string name,
                               output int xs[4], output int ys[4]);
    applyStimulus(1'b1, 1'b0, 1'b0);
    idleUntilCnt(target);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int p = 0; p < 4; p++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("%s_pulse%0d", name, p), m_x, m_y);
      xs[p] = int'(O_box_x);
      ys[p] = int'(O_box_y);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    int prevX;
    int prevY;
    int updates;
    int differ;
    int missCols;
    int badCols;
    int missRows;
    int badRows;
    int seqAx[4];
    int seqAy[4];
    int seqBx[4];
    int seqBy[4];

    I_rst   = 1'b1;
    I_load  = 1'b0;
    I_drive = 1'b0;

    // Known values: seed 0xACE1 maps to column 33 row 12; its successor
    // 0xE270 exercises the fold of column field 48 back into range
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 320, 240};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 320, 240};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, X_ACE1, Y_ACE1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, X_ACE1, Y_ACE1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, X_ACE1, Y_ACE1};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 320, 240};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 320, 240};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, X_E270, Y_E270};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, X_E270, Y_E270};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 320, 240};
    tbl[10] = '{1'b0, 1'b0, 1'b1, X_ACE1, Y_ACE1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, X_ACE1, Y_ACE1};

    for (int i = 0; i < 12; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].load, tbl[i].drive);
      checkOutput($sformatf("table%0d", i), tbl[i].exp_x, tbl[i].exp_y);
    end

    // Reset value held through idle cycles
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("idle%0d", i), 320, 240);
    end

    // Single pulse
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("singlePulse", m_x, m_y);
    checkRange("singlePulseRange");
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("singlePulseHold", m_x, m_y);

    // Held drive produces one update only
    prevX = int'(O_box_x);
    prevY = int'(O_box_y);
    updates = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput($sformatf("held%0d", i), m_x, m_y);
      if (int'(O_box_x) != prevX || int'(O_box_y) != prevY) updates++;
      prevX = int'(O_box_x);
      prevY = int'(O_box_y);
    end
    checkValue("heldUpdates", updates, 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("afterHeldPulse", m_x, m_y);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Load and generate in the same cycle use the pre-load LFSR
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("loadWithDrive", m_x, m_y);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("afterLoadWithDrive", m_x, m_y);

    // Reseed from the cycle counter at two different cycles
    loadAndSample(40, "load40", seqAx, seqAy);
    loadAndSample(100, "load100", seqBx, seqBy);
    differ = 0;
    for (int p = 0; p < 4; p++) begin
      if (seqAx[p] != seqBx[p] || seqAy[p] != seqBy[p]) differ = 1;
    end
    checkValue("loadSeqDiffers", differ, 1);

    // Randomized drive pulses with occasional reseeds
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int p = 0; p < 10000; p++) begin
      int hold;
      int gap;
      hold = $urandom_range(1, 3);
      gap  = $urandom_range(1, 2);
      for (int h = 0; h < hold; h++) begin
        applyStimulus(1'b0, ($urandom_range(0, 15) == 0), 1'b1);
        checkOutput("randDrive", m_x, m_y);
        checkRange("randRange");
        if (O_box_x[3:0] == 4'd0 && int'(O_box_x) <= 624) colSeen[int'(O_box_x) / 16] = 1'b1;
        if (O_box_y[3:0] == 4'd0 && int'(O_box_y) <= 464) rowSeen[int'(O_box_y) / 16] = 1'b1;
      end
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, ($urandom_range(0, 15) == 0), 1'b0);
        checkOutput("randGap", m_x, m_y);
      end
    end

    missCols = 0;
    badCols = 0;
    for (int c = 0; c < 40; c++) begin
      if (c >= OFF && c < NX + OFF) begin
        if (!colSeen[c]) missCols++;
      end else if (colSeen[c]) begin
        badCols++;
      end
    end
    missRows = 0;
    badRows = 0;
    for (int r = 0; r < 30; r++) begin
      if (r >= OFF && r < NY + OFF) begin
        if (!rowSeen[r]) missRows++;
      end else if (rowSeen[r]) begin
        badRows++;
      end
    end
    checkValue("colsMissing", missCols, 0);
    checkValue("colsForbidden", badCols, 0);
    checkValue("rowsMissing", missRows, 0);
    checkValue("rowsForbidden", badRows, 0);

    // Reset colliding with a drive edge
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("resetOnEdge", 320, 240);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("resetOnEdgeAfter", 320, 240);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
